latch_wr_arbiter: RTL

Clocked write controller for a shared bank of level-sensitive D latches (`dlatch` cells, one word per enable line). It arbitrates round-robin between NREQ synchronous requesters and sequences each write. The sequence is a setup phase with data driven and enable low, then an enable pulse of programmable width, then a hold phase with enable low and data still driven. This guarantees the latch transparency window never overlaps a data change. It sits between the clocked requesters and the latch bank, and is the only block allowed to drive the bank's `d`/`en` pins.

---
 rtl/latch_ctrl_pkg.sv | 5 +
 rtl/rr_arbiter.sv | 18 +
 rtl/latch_wr_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg: write-sequencer state encoding and pulse-counter width
package latch_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} lw_state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; req+ptr in, first set bit at/after ptr out as one-hot grant and idx
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    grant[idx] = |req;
  end
endmodule

// File: rtl/latch_wr_arbiter.sv
// latch_wr_arbiter: round-robin latch-bank write sequencer (setup/pulse/hold); in clk,rst_n,req,req_addr,req_data; out ack,busy,lat_d,lat_en
module latch_wr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int AW        = 2,
  parameter int EN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic [DW-1:0]        lat_d,
  output logic [(2**AW)-1:0]   lat_en
);
  localparam int IW = $clog2(NREQ);
  localparam int NW = 2 ** AW;
  lw_state_t        state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gidx;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  gnt_q;
  logic [AW-1:0]    addr_q;
  logic [CNT_W-1:0] cnt;
  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      ack    <= '0;
      busy   <= 1'b0;
      lat_d  <= '0;
      lat_en <= '0;
      ptr    <= '0;
      cnt    <= '0;
      gnt_q  <= '0;
      addr_q <= '0;
    end else
      case (state)
        IDLE:
          if (|req) begin
            state  <= SETUP;
            busy   <= 1'b1;
            gnt_q  <= grant;
            addr_q <= req_addr[gidx*AW +: AW];
            lat_d  <= req_data[gidx*DW +: DW];
            ptr    <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          end
        SETUP: begin
          state  <= PULSE;
          cnt    <= CNT_W'(EN_CYCLES - 1);
          lat_en <= NW'(1) << addr_q;
        end
        PULSE:
          if (cnt == '0) begin
            state  <= HOLD;
            lat_en <= '0;
            ack    <= gnt_q;
          end else
            cnt <= cnt - 1'b1;
        HOLD: begin
          state <= IDLE;
          ack   <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule
